// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard-controller state encoding and the bundle of
// pipeline control outputs, with the two fixed patterns the controller uses.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_FLUSH  = 2'd1,
    HZ_HALTED = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic fl_ifid;
    logic fl_idex;
    logic fl_exmem;
    logic fl_memwb;
    logic dmem_block;
  } hz_ctl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  localparam hz_ctl_t CTL_RUN = '{
    pc_en: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
    fl_ifid: 1'b0, fl_idex: 1'b0, fl_exmem: 1'b0, fl_memwb: 1'b0,
    dmem_block: 1'b0
  };

  // Frozen pipeline used from the halt cycle onward.
  localparam hz_ctl_t CTL_FREEZE = '{
    pc_en: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0, en_memwb: 1'b0,
    fl_ifid: 1'b0, fl_idex: 1'b0, fl_exmem: 1'b0, fl_memwb: 1'b0,
    dmem_block: 1'b1
  };

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of all non-clock hazard-controller signals, with one modport for the
// controller and one for the datapath that drives it.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             nRST;
  logic             ihit;
  logic             dhit;
  logic             dmemREN_mem;
  logic             dmemWEN_mem;
  logic             memRead_ex;
  logic [REG_W-1:0] regSel_ex;
  logic [REG_W-1:0] rs_id;
  logic [REG_W-1:0] rt_id;
  logic             jump_id;
  logic             brTaken_mem;
  logic             halt_wb;
  logic             dflush_done;
  logic             pc_en;
  logic             en_ifid, en_idex, en_exmem, en_memwb;
  logic             fl_ifid, fl_idex, fl_exmem, fl_memwb;
  logic             dmem_block;
  logic             dflush_req;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport ctrl (
    input  nRST, ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex, regSel_ex,
           rs_id, rt_id, jump_id, brTaken_mem, halt_wb, dflush_done,
    output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           fl_ifid, fl_idex, fl_exmem, fl_memwb, dmem_block,
           dflush_req, halt, stall_cnt, flush_cnt
  );

  modport dp (
    output nRST, ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex, regSel_ex,
           rs_id, rt_id, jump_id, brTaken_mem, halt_wb, dflush_done,
    input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           fl_ifid, fl_idex, fl_exmem, fl_memwb, dmem_block,
           dflush_req, halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping; clr wins
// over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: assign a default first so every path drives count_d; a missing
    // else branch in always_comb would otherwise infer a latch.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values,
    // independent of the order blocks are evaluated in.
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: latch enables/flushes, PC enable, halt ->
// dcache-flush handshake, and stall/redirect performance counters.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             memRead_ex,
  input  logic [REG_W-1:0] regSel_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             jump_id,
  input  logic             brTaken_mem,
  input  logic             halt_wb,
  input  logic             dflush_done,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             fl_ifid,
  output logic             fl_idex,
  output logic             fl_exmem,
  output logic             fl_memwb,
  output logic             dmem_block,
  output logic             dflush_req,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t state_q, state_d;
  logic      dflush_req_q, dflush_req_d;
  logic      halt_q, halt_d;
  hz_ctl_t   ctl;
  logic      redirect;
  logic      dwait, loaduse;
  logic      stall_inc, flush_inc;

  assign dwait   = (dmemREN_mem | dmemWEN_mem) & ~dhit;
  assign loaduse = memRead_ex && (regSel_ex != '0) &&
                   ((regSel_ex == rs_id) || (regSel_ex == rt_id));

  always_comb begin
    state_d  = state_q;
    ctl      = CTL_RUN;
    redirect = 1'b0;
    unique case (state_q)
      HZ_RUN: begin
        if (halt_wb) begin
          ctl     = CTL_FREEZE;
          state_d = HZ_FLUSH;
        end else if (dwait) begin
          // Hold IF..EX; MEM/WB advances with a bubble so WB cannot repeat.
          ctl.pc_en    = 1'b0;
          ctl.en_ifid  = 1'b0;
          ctl.en_idex  = 1'b0;
          ctl.en_exmem = 1'b0;
          ctl.fl_memwb = 1'b1;
        end else if (brTaken_mem) begin
          ctl.fl_ifid  = 1'b1;
          ctl.fl_idex  = 1'b1;
          ctl.fl_exmem = 1'b1;
          redirect     = 1'b1;
        end else if (loaduse) begin
          ctl.pc_en   = 1'b0;
          ctl.en_ifid = 1'b0;
          ctl.fl_idex = 1'b1;
        end else if (jump_id) begin
          // The jump target is loaded even on an icache miss.
          ctl.fl_ifid = 1'b1;
          redirect    = 1'b1;
        end else if (!ihit) begin
          ctl.pc_en   = 1'b0;
          ctl.fl_ifid = 1'b1;
        end
      end
      HZ_FLUSH: begin
        ctl = CTL_FREEZE;
        if (dflush_done) state_d = HZ_HALTED;
      end
      HZ_HALTED: ctl = CTL_FREEZE;
      default: begin
        ctl     = CTL_FREEZE;
        state_d = HZ_RUN;
      end
    endcase
    dflush_req_d = (state_d == HZ_FLUSH);
    halt_d       = (state_d == HZ_HALTED);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= HZ_RUN;
      dflush_req_q <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dflush_req_q <= dflush_req_d;
      halt_q       <= halt_d;
    end
  end

  assign stall_inc = (state_q == HZ_RUN) && !ctl.pc_en;
  assign flush_inc = redirect;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .clr   (1'b0),
    .count (flush_cnt)
  );

  assign pc_en      = ctl.pc_en;
  assign en_ifid    = ctl.en_ifid;
  assign en_idex    = ctl.en_idex;
  assign en_exmem   = ctl.en_exmem;
  assign en_memwb   = ctl.en_memwb;
  assign fl_ifid    = ctl.fl_ifid;
  assign fl_idex    = ctl.fl_idex;
  assign fl_exmem   = ctl.fl_exmem;
  assign fl_memwb   = ctl.fl_memwb;
  assign dmem_block = ctl.dmem_block;
  assign dflush_req = dflush_req_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: priority resolution, counters, halt/flush
// handshake, asynchronous reset, and saturation on a narrow-counter instance.
module tb_hazard_ctrl;

  // Control vector order: pc_en, en_ifid, en_idex, en_exmem, en_memwb,
  //                       fl_ifid, fl_idex, fl_exmem, fl_memwb, dmem_block
  localparam logic [9:0] C_RUN    = 10'b1_1111_0000_0;
  localparam logic [9:0] C_DWAIT  = 10'b0_0001_0001_0;
  localparam logic [9:0] C_BR     = 10'b1_1111_1110_0;
  localparam logic [9:0] C_LU     = 10'b0_0111_0100_0;
  localparam logic [9:0] C_JMP    = 10'b1_1111_1000_0;
  localparam logic [9:0] C_IMISS  = 10'b0_1111_1000_0;
  localparam logic [9:0] C_FREEZE = 10'b0_0000_0000_1;

  logic CLK;
  hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) hif ();

  logic       s_pc_en, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb;
  logic       s_fl_ifid, s_fl_idex, s_fl_exmem, s_fl_memwb, s_dmem_block;
  logic       s_dflush_req, s_halt;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  logic [9:0] ctl;
  assign ctl = {hif.pc_en, hif.en_ifid, hif.en_idex, hif.en_exmem, hif.en_memwb,
                hif.fl_ifid, hif.fl_idex, hif.fl_exmem, hif.fl_memwb, hif.dmem_block};

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .CLK         (CLK),
    .nRST        (hif.nRST),
    .ihit        (hif.ihit),
    .dhit        (hif.dhit),
    .dmemREN_mem (hif.dmemREN_mem),
    .dmemWEN_mem (hif.dmemWEN_mem),
    .memRead_ex  (hif.memRead_ex),
    .regSel_ex   (hif.regSel_ex),
    .rs_id       (hif.rs_id),
    .rt_id       (hif.rt_id),
    .jump_id     (hif.jump_id),
    .brTaken_mem (hif.brTaken_mem),
    .halt_wb     (hif.halt_wb),
    .dflush_done (hif.dflush_done),
    .pc_en       (hif.pc_en),
    .en_ifid     (hif.en_ifid),
    .en_idex     (hif.en_idex),
    .en_exmem    (hif.en_exmem),
    .en_memwb    (hif.en_memwb),
    .fl_ifid     (hif.fl_ifid),
    .fl_idex     (hif.fl_idex),
    .fl_exmem    (hif.fl_exmem),
    .fl_memwb    (hif.fl_memwb),
    .dmem_block  (hif.dmem_block),
    .dflush_req  (hif.dflush_req),
    .halt        (hif.halt),
    .stall_cnt   (hif.stall_cnt),
    .flush_cnt   (hif.flush_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut_sat (
    .CLK         (CLK),
    .nRST        (hif.nRST),
    .ihit        (hif.ihit),
    .dhit        (hif.dhit),
    .dmemREN_mem (hif.dmemREN_mem),
    .dmemWEN_mem (hif.dmemWEN_mem),
    .memRead_ex  (hif.memRead_ex),
    .regSel_ex   (hif.regSel_ex),
    .rs_id       (hif.rs_id),
    .rt_id       (hif.rt_id),
    .jump_id     (hif.jump_id),
    .brTaken_mem (hif.brTaken_mem),
    .halt_wb     (hif.halt_wb),
    .dflush_done (hif.dflush_done),
    .pc_en       (s_pc_en),
    .en_ifid     (s_en_ifid),
    .en_idex     (s_en_idex),
    .en_exmem    (s_en_exmem),
    .en_memwb    (s_en_memwb),
    .fl_ifid     (s_fl_ifid),
    .fl_idex     (s_fl_idex),
    .fl_exmem    (s_fl_exmem),
    .fl_memwb    (s_fl_memwb),
    .dmem_block  (s_dmem_block),
    .dflush_req  (s_dflush_req),
    .halt        (s_halt),
    .stall_cnt   (s_stall_cnt),
    .flush_cnt   (s_flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    hif.ihit        = 1'b1;
    hif.dhit        = 1'b1;
    hif.dmemREN_mem = 1'b0;
    hif.dmemWEN_mem = 1'b0;
    hif.memRead_ex  = 1'b0;
    hif.regSel_ex   = '0;
    hif.rs_id       = '0;
    hif.rt_id       = '0;
    hif.jump_id     = 1'b0;
    hif.brTaken_mem = 1'b0;
    hif.halt_wb     = 1'b0;
    hif.dflush_done = 1'b0;
  endtask

  initial begin
    hif.nRST = 1'b0;
    idle();
    #2;
    check("rst_ctl", ctl, C_RUN);
    check("rst_dflush_req", hif.dflush_req, 0);
    check("rst_halt", hif.halt, 0);
    check("rst_stall_cnt", hif.stall_cnt, 0);
    check("rst_flush_cnt", hif.flush_cnt, 0);
    #10 hif.nRST = 1'b1;
    tick();

    // Dcache read miss for three cycles, then hit.
    hif.dmemREN_mem = 1'b1;
    hif.dhit = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("dmiss_ctl", ctl, C_DWAIT);
      tick();
    end
    check("dmiss_stall_cnt", hif.stall_cnt, 3);
    hif.dhit = 1'b1;
    #1 check("dhit_ctl", ctl, C_RUN);
    tick();
    check("dhit_stall_cnt", hif.stall_cnt, 3);
    idle();

    // Store miss beats a taken branch; no redirect counted.
    hif.dmemWEN_mem = 1'b1;
    hif.dhit = 1'b0;
    hif.brTaken_mem = 1'b1;
    #1 check("dwait_over_br_ctl", ctl, C_DWAIT);
    tick();
    check("dwait_over_br_stall", hif.stall_cnt, 4);
    check("dwait_over_br_flush", hif.flush_cnt, 0);
    idle();

    // Load-use on rs, then the bubble cycle.
    hif.memRead_ex = 1'b1;
    hif.regSel_ex = 5'd5;
    hif.rs_id = 5'd5;
    #1 check("lu_rs_ctl", ctl, C_LU);
    tick();
    check("lu_rs_stall", hif.stall_cnt, 5);
    hif.memRead_ex = 1'b0;
    #1 check("lu_bubble_ctl", ctl, C_RUN);
    tick();

    // Load-use on rt.
    hif.memRead_ex = 1'b1;
    hif.regSel_ex = 5'd7;
    hif.rs_id = 5'd3;
    hif.rt_id = 5'd7;
    #1 check("lu_rt_ctl", ctl, C_LU);
    tick();
    check("lu_rt_stall", hif.stall_cnt, 6);

    // Load into r0 never stalls; stray dflush_done in RUN is ignored.
    hif.regSel_ex = '0;
    hif.rs_id = '0;
    hif.rt_id = '0;
    hif.dflush_done = 1'b1;
    #1 check("lu_r0_ctl", ctl, C_RUN);
    tick();
    check("lu_r0_stall", hif.stall_cnt, 6);
    check("stray_done_req", hif.dflush_req, 0);
    check("stray_done_halt", hif.halt, 0);
    idle();

    // Branch beats concurrent load-use and jump.
    hif.brTaken_mem = 1'b1;
    hif.memRead_ex = 1'b1;
    hif.regSel_ex = 5'd5;
    hif.rs_id = 5'd5;
    hif.jump_id = 1'b1;
    #1 check("br_lu_ctl", ctl, C_BR);
    tick();
    check("br_flush_cnt", hif.flush_cnt, 1);
    check("br_stall_cnt", hif.stall_cnt, 6);
    idle();

    // Jump, then jump during an icache miss.
    hif.jump_id = 1'b1;
    #1 check("jmp_ctl", ctl, C_JMP);
    tick();
    check("jmp_flush_cnt", hif.flush_cnt, 2);
    hif.ihit = 1'b0;
    #1 check("jmp_imiss_ctl", ctl, C_JMP);
    tick();
    check("jmp_imiss_flush", hif.flush_cnt, 3);
    check("jmp_imiss_stall", hif.stall_cnt, 6);

    // Load-use beats jump.
    hif.ihit = 1'b1;
    hif.memRead_ex = 1'b1;
    hif.regSel_ex = 5'd5;
    hif.rs_id = 5'd5;
    #1 check("lu_over_jmp_ctl", ctl, C_LU);
    tick();
    check("lu_over_jmp_flush", hif.flush_cnt, 3);
    check("lu_over_jmp_stall", hif.stall_cnt, 7);
    idle();

    // Plain icache miss.
    hif.ihit = 1'b0;
    #1 check("imiss_ctl", ctl, C_IMISS);
    tick();
    check("imiss_stall", hif.stall_cnt, 8);
    idle();

    // Halt sequence; hazards during FLUSH must not leak through or count.
    hif.halt_wb = 1'b1;
    #1 check("halt_wb_ctl", ctl, C_FREEZE);
    check("halt_wb_req", hif.dflush_req, 0);
    tick();
    hif.halt_wb = 1'b0;
    check("halt_wb_stall", hif.stall_cnt, 9);
    hif.ihit = 1'b0;
    hif.brTaken_mem = 1'b1;
    hif.jump_id = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("flush_req", hif.dflush_req, 1);
      check("flush_halt", hif.halt, 0);
      check("flush_ctl", ctl, C_FREEZE);
      tick();
    end
    hif.dflush_done = 1'b1;
    #1 check("done_ctl", ctl, C_FREEZE);
    tick();
    hif.dflush_done = 1'b0;
    check("halted_req", hif.dflush_req, 0);
    check("halted_halt", hif.halt, 1);
    repeat (3) tick();
    check("halted_sticky", hif.halt, 1);
    check("halted_ctl", ctl, C_FREEZE);
    check("halted_stall_frozen", hif.stall_cnt, 9);
    check("halted_flush_frozen", hif.flush_cnt, 3);

    // Reset asserted mid-FLUSH drops everything asynchronously.
    hif.nRST = 1'b0;
    #2 hif.nRST = 1'b1;
    idle();
    tick();
    hif.halt_wb = 1'b1;
    tick();
    hif.halt_wb = 1'b0;
    check("reflush_req", hif.dflush_req, 1);
    #3 hif.nRST = 1'b0;
    #1;
    check("async_rst_req", hif.dflush_req, 0);
    check("async_rst_halt", hif.halt, 0);
    check("async_rst_ctl", ctl, C_RUN);
    check("async_rst_stall", hif.stall_cnt, 0);
    #2 hif.nRST = 1'b1;

    // Saturation: 20 icache-miss cycles.
    hif.ihit = 1'b0;
    repeat (15) tick();
    check("sat_at_max", s_stall_cnt, 15);
    check("wide_at_15", hif.stall_cnt, 15);
    repeat (5) tick();
    check("sat_holds", s_stall_cnt, 15);
    check("wide_at_20", hif.stall_cnt, 20);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
